// File: rtl/decoder_pkg.sv
// Shared types and defaults for the pipelined one-hot decoder.
// Build option DEC_RANGE_CHECK_EN is resolved in the top level, not here.
package decoder_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } dec_state_t;

   localparam int DEC_SEL_WIDTH_DEF   = 5;
   localparam int DEC_NUM_OUTPUTS_DEF = 32;

   // Reference decode at default widths; indices at or above num_outputs give all-zero.
   function automatic logic [DEC_NUM_OUTPUTS_DEF-1:0] onehot_decode(
      input logic [DEC_SEL_WIDTH_DEF-1:0] idx,
      input int                           num_outputs
   );
      logic [DEC_NUM_OUTPUTS_DEF-1:0] result;
      result = '0;
      for (int k = 0; k < DEC_NUM_OUTPUTS_DEF; k++) begin
         result[k] = (k < num_outputs) && (32'(idx) == 32'(k));
      end
      return result;
   endfunction

endpackage

// File: rtl/decoder_skid_buffer.sv
// Two-entry FIFO skid buffer holding decoded words; owns the occupancy FSM.
// in_push/out_pop arrive already qualified by the caller's handshake and enable.
module decoder_skid_buffer
   import decoder_pkg::*;
#(
   parameter int WIDTH = DEC_NUM_OUTPUTS_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_push,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_pop
);

   dec_state_t       state_reg, state_next;
   logic [WIDTH-1:0] head_reg, head_next;
   logic [WIDTH-1:0] tail_reg, tail_next;
   logic             ready_reg;
   logic             push_ok, pop_ok;

   assign push_ok = in_push & (state_reg != TWO);
   assign pop_ok  = out_pop & (state_reg != EMPTY);

   always_comb begin
      state_next = state_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      case (state_reg)
         EMPTY: begin
            if (push_ok) begin
               head_next  = in_data;
               state_next = ONE;
            end
         end
         ONE: begin
            // Concurrent push and pop replaces the head directly, so no bubble.
            if (push_ok && pop_ok) begin
               head_next = in_data;
            end else if (push_ok) begin
               tail_next  = in_data;
               state_next = TWO;
            end else if (pop_ok) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (pop_ok) begin
               head_next  = tail_reg;
               state_next = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         head_reg  <= '0;
         tail_reg  <= '0;
         ready_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         ready_reg <= (state_next != TWO);
      end
   end

   assign in_ready  = ready_reg;
   assign out_data  = head_reg;
   assign out_valid = (state_reg != EMPTY);

endmodule

// File: rtl/pipelined_decoder_5_32.sv
// Streaming binary-to-one-hot decoder with a 2-deep skid buffer on the output side.
// Define DEC_RANGE_CHECK_EN to drop out-of-range indices and flag them on Range_Error_Out.
module pipelined_decoder_5_32
   import decoder_pkg::*;
#(
   parameter int SEL_WIDTH   = DEC_SEL_WIDTH_DEF,
   parameter int NUM_OUTPUTS = DEC_NUM_OUTPUTS_DEF
) (
   input  logic                   Clock_In,
   input  logic                   Reset_n_In,
   input  logic                   Enable_In,
   input  logic [SEL_WIDTH-1:0]   Index_In,
   input  logic                   Index_Valid_In,
   output logic                   Index_Ready_Out,
   output logic [NUM_OUTPUTS-1:0] Decoded_Out,
   output logic                   Decoded_Valid_Out,
   input  logic                   Decoded_Ready_In
`ifdef DEC_RANGE_CHECK_EN
   ,
   output logic                   Range_Error_Out
`endif
);

   logic [NUM_OUTPUTS-1:0] decoded;
   logic [NUM_OUTPUTS-1:0] buf_data;
   logic                   buf_valid;
   logic                   buf_ready;
   logic                   in_fire;
   logic                   out_fire;
   logic                   push;

   for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_decode
      assign decoded[gi] = (32'(Index_In) == 32'(gi));
   end

   assign Index_Ready_Out = buf_ready & Enable_In;
   assign in_fire         = Index_Valid_In & Index_Ready_Out;
   assign out_fire        = buf_valid & Decoded_Ready_In & Enable_In;

`ifdef DEC_RANGE_CHECK_EN
   logic out_of_range;
   logic range_err_reg;

   // Out-of-range indices are consumed without occupying a buffer slot.
   assign out_of_range = (32'(Index_In) >= 32'(NUM_OUTPUTS));
   assign push         = in_fire & ~out_of_range;

   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         range_err_reg <= 1'b0;
      end else begin
         range_err_reg <= in_fire & out_of_range;
      end
   end

   assign Range_Error_Out = range_err_reg;
`else
   assign push = in_fire;
`endif

   decoder_skid_buffer #(
      .WIDTH (NUM_OUTPUTS)
   ) u_skid (
      .clk       (Clock_In),
      .rst_n     (Reset_n_In),
      .in_data   (decoded),
      .in_push   (push),
      .in_ready  (buf_ready),
      .out_data  (buf_data),
      .out_valid (buf_valid),
      .out_pop   (out_fire)
   );

   assign Decoded_Out       = Enable_In ? buf_data : {NUM_OUTPUTS{1'bz}};
   assign Decoded_Valid_Out = buf_valid & Enable_In;

endmodule

// File: tb/tb_pipelined_decoder_5_32.sv
// Directed bench for pipelined_decoder_5_32 with a queue scoreboard; a second
// 20-output instance covers out-of-range indices in either DEC_RANGE_CHECK_EN build.
module tb_pipelined_decoder_5_32;

   localparam logic [31:0] Z32 = 'z;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [4:0]  idx;
   logic        ivalid;
   logic        dready;
   wire         iready;
   wire  [31:0] dout;
   wire         dvalid;

   logic        en_b;
   logic [4:0]  idx_b;
   logic        ivalid_b;
   logic        dready_b;
   wire         iready_b;
   wire  [19:0] dout_b;
   wire         dvalid_b;
`ifdef DEC_RANGE_CHECK_EN
   wire         rerr;
   wire         rerr_b;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   pipelined_decoder_5_32 dut (
      .Clock_In          (clk),
      .Reset_n_In        (rst_n),
      .Enable_In         (en),
      .Index_In          (idx),
      .Index_Valid_In    (ivalid),
      .Index_Ready_Out   (iready),
      .Decoded_Out       (dout),
      .Decoded_Valid_Out (dvalid),
      .Decoded_Ready_In  (dready)
`ifdef DEC_RANGE_CHECK_EN
      ,
      .Range_Error_Out   (rerr)
`endif
   );

   pipelined_decoder_5_32 #(
      .SEL_WIDTH   (5),
      .NUM_OUTPUTS (20)
   ) dut20 (
      .Clock_In          (clk),
      .Reset_n_In        (rst_n),
      .Enable_In         (en_b),
      .Index_In          (idx_b),
      .Index_Valid_In    (ivalid_b),
      .Index_Ready_Out   (iready_b),
      .Decoded_Out       (dout_b),
      .Decoded_Valid_Out (dvalid_b),
      .Decoded_Ready_In  (dready_b)
`ifdef DEC_RANGE_CHECK_EN
      ,
      .Range_Error_Out   (rerr_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_of(input logic [4:0] i);
      return 32'd1 << i;
   endfunction

   task automatic check_state();
      chk("ready", 32'(iready), 32'(en && sb.size() < 2));
      chk("valid", 32'(dvalid), 32'(en && sb.size() > 0));
      if (!en) chk("dout_z", dout, Z32);
      else if (sb.size() > 0) chk("dout_head", dout, sb[0]);
`ifdef DEC_RANGE_CHECK_EN
      chk("rerr_main", 32'(rerr), 32'd0);
`endif
   endtask

   // Evaluate handshakes just before the edge, update the scoreboard, then check after it.
   task automatic tick();
      logic in_f, out_f;
      #1;
      in_f  = ivalid && iready && en;
      out_f = dvalid && dready && en;
      if (out_f) begin
         if (sb.size() == 0) chk("pop_unexpected", 32'(dvalid), 32'd0);
         else begin
            chk("pop", dout, sb[0]);
            void'(sb.pop_front());
         end
      end
      if (in_f) sb.push_back(exp_of(idx));
      $display("txn idx=%0d in=%0b out=%0b dout=%h depth=%0d", idx, in_f, out_f, dout, sb.size());
      @(posedge clk);
      @(negedge clk);
      check_state();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; idx = '0; ivalid = 1'b0; dready = 1'b0;
      en_b = 1'b1; idx_b = '0; ivalid_b = 1'b0; dready_b = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(dvalid), 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_ready", 32'(iready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_valid", 32'(dvalid), 32'd0);
      chk("rel_ready", 32'(iready), 32'd1);
      chk("rel_dout", dout, 32'd0);

      // Full-rate stream with downstream always ready.
      dready = 1'b1;
      ivalid = 1'b1;
      idx = 5'd0;  tick();
      idx = 5'd5;  tick();
      idx = 5'd31; tick();
      ivalid = 1'b0;
      tick();
      tick();

      // Backpressure fills both entries; a third index must be refused.
      dready = 1'b0;
      ivalid = 1'b1;
      idx = 5'd3; tick();
      idx = 5'd7; tick();
      idx = 5'd9; tick();
      tick();

      // Disabled with two entries held: no handshakes, output floats.
      en = 1'b0;
      dready = 1'b1;
      tick();
      tick();
      tick();
      ivalid = 1'b0;
      en = 1'b1;
      tick();
      tick();
      tick();

      // Async reset with the buffer full.
      dready = 1'b0;
      ivalid = 1'b1;
      idx = 5'd12; tick();
      idx = 5'd13; tick();
      ivalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(dvalid), 32'd0);
      chk("arst_dout", dout, 32'd0);
      chk("arst_ready", 32'(iready), 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      dready = 1'b1;
      tick();
      tick();
      ivalid = 1'b1;
      idx = 5'd17; tick();
      ivalid = 1'b0;
      tick();

      // Out-of-range index on the 20-output instance.
      ivalid_b = 1'b1;
      idx_b = 5'd25;
      @(posedge clk);
      @(negedge clk);
      ivalid_b = 1'b0;
`ifdef DEC_RANGE_CHECK_EN
      chk("oor_rerr_pulse", 32'(rerr_b), 32'd1);
      chk("oor_not_emitted", 32'(dvalid_b), 32'd0);
      @(negedge clk);
      chk("oor_rerr_clear", 32'(rerr_b), 32'd0);
      chk("oor_still_empty", 32'(dvalid_b), 32'd0);
`else
      chk("oor_valid", 32'(dvalid_b), 32'd1);
      chk("oor_zero", 32'(dout_b), 32'd0);
      @(negedge clk);
      chk("oor_drained", 32'(dvalid_b), 32'd0);
`endif
      $display("txn dut20 idx=25 dout=%h valid=%0b", dout_b, dvalid_b);
      ivalid_b = 1'b1;
      idx_b = 5'd19;
      @(posedge clk);
      @(negedge clk);
      ivalid_b = 1'b0;
      chk("n20_top_valid", 32'(dvalid_b), 32'd1);
      chk("n20_top_dout", 32'(dout_b), 32'h0008_0000);
      $display("txn dut20 idx=19 dout=%h valid=%0b", dout_b, dvalid_b);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
